// File: rtl/lat_wr_sched_pkg.sv
// Shared types for the latch-array write scheduler.
//   state_e : write sequencing phases (idle, setup, open, hold)
package lat_wr_sched_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StOpen  = 2'd2,
        StHold  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : highest-priority index; search runs upward from here modulo N
//   gnt    : one-hot grant (zero when no request)
//   gnt_id : binary index of the granted requester (zero when no request)
module rr_arb #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IW'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/lat_wr_sched.sv
// Write scheduler for a latch-based register file.
// Arbitrates N requesters round-robin, captures the winner's address/data and
// sequences the write through setup, open and hold phases so the shared latch
// data is stable a full cycle before and after the one-hot enable pulse.
//   clk, nreset : clock, asynchronous active-low reset
//   req_valid   : per-requester write request
//   req_ready   : per-requester grant (combinational from state, ptr, req_valid)
//   req_addr    : packed addresses, requester i at [i*AW +: AW]
//   req_data    : packed data, requester i at [i*DW +: DW]
//   le          : one-hot latch enables, flopped directly
//   wr_data     : shared latch input data
//   wr_addr     : address of the write in flight
//   busy        : write in flight
//   wr_done     : high during the hold phase
module lat_wr_sched
    import lat_wr_sched_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 3
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [N-1:0]        req_valid,
    output logic [N-1:0]        req_ready,
    input  logic [N*AW-1:0]     req_addr,
    input  logic [N*DW-1:0]     req_data,
    output logic [(2**AW)-1:0]  le,
    output logic [DW-1:0]       wr_data,
    output logic [AW-1:0]       wr_addr,
    output logic                busy,
    output logic                wr_done
);

    localparam int unsigned Depth = 2 ** AW;
    localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1;

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [Depth-1:0] le_q, le_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic             busy_q, wr_done_q;

    logic [N-1:0]     gnt;
    logic [IW-1:0]    gnt_id;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic             arb_en;
    logic             hs;

    rr_arb #(
        .N (N)
    ) u_rr_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Grants are only offered while idle or holding; reset also masks them.
    assign arb_en    = (state_q == StIdle) || (state_q == StHold);
    assign req_ready = (arb_en && nreset) ? gnt : '0;
    assign hs        = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_id == IW'(i)) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        le_d      = '0;
        unique case (state_q)
            StIdle, StHold: begin
                if (hs) begin
                    state_d   = StSetup;
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
                    ptr_d     = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StSetup: begin
                state_d         = StOpen;
                // Decode here so le comes straight off a flop during OPEN.
                le_d[wr_addr_q] = 1'b1;
            end
            StOpen: begin
                state_d = StHold;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            le_q      <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            le_q      <= le_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            busy_q    <= (state_d != StIdle);
            wr_done_q <= (state_d == StHold);
        end
    end

    assign le      = le_q;
    assign wr_data = wr_data_q;
    assign wr_addr = wr_addr_q;
    assign busy    = busy_q;
    assign wr_done = wr_done_q;

endmodule
